// File: rtl/des_buffer_ctrl.sv
// rtl/des_buffer_ctrl.sv - 3DES buffer stage: input/output word FIFOs, key registers, block dispatch FSM.
module des_buffer_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [2:0]  mode,
  input  logic [31:0] PWDATA,
  input  logic        core_ready,
  input  logic        core_done,
  input  logic [63:0] core_result,
  output logic [3:0]  data_in_cnt,
  output logic [3:0]  data_out_cnt,
  output logic [31:0] data_out,
  output logic        core_start,
  output logic [63:0] core_block,
  output logic        core_decrypt,
  output logic        core_flush,
  output logic [63:0] key1,
  output logic [63:0] key2
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] MODE_ENC  = 3'd1;
  localparam logic [2:0] MODE_DEC  = 3'd2;
  localparam logic [2:0] MODE_KEY1 = 3'd3;
  localparam logic [2:0] MODE_KEY2 = 3'd4;
  localparam logic [2:0] MODE_SRST = 3'd5;
  localparam logic [2:0] MODE_POP  = 3'd6;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
  state_t state, next_state;

  logic [32:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wr, in_rd, out_wr, out_rd;
  logic          key1_half, key2_half;
  logic          soft_rst, push_in, dispatch, capture, pop_out;

  assign soft_rst = (mode == MODE_SRST);
  assign push_in  = ((mode == MODE_ENC) || (mode == MODE_DEC)) && (data_in_cnt != 4'(DEPTH));
  assign pop_out  = (mode == MODE_POP) && (data_out_cnt != 4'd0);
  // One block in flight at most, so room for 2 results at dispatch time rules out overflow.
  assign dispatch = (state == IDLE) && (data_in_cnt >= 4'd2) && core_ready &&
                    (data_out_cnt <= 4'(DEPTH - 2));
  assign capture  = (state == BUSY) && core_done;

  assign core_start = (state == START);
  assign data_out   = (data_out_cnt == 4'd0) ? 32'd0 : out_mem[out_rd];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (dispatch) next_state = START;
      START:   next_state = BUSY;
      BUSY:    if (core_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= next_state;
  end

  // Storage arrays need no reset: the counts gate every read.
  always_ff @(posedge clk) begin
    if (push_in && !soft_rst) in_mem[in_wr] <= {(mode == MODE_DEC), PWDATA};
    if (capture && !soft_rst) begin
      out_mem[out_wr]           <= core_result[63:32];
      out_mem[out_wr + AW'(1)]  <= core_result[31:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst || soft_rst) begin
      in_wr <= '0; in_rd <= '0; data_in_cnt <= '0;
      out_wr <= '0; out_rd <= '0; data_out_cnt <= '0;
    end else begin
      if (push_in)  in_wr  <= in_wr + AW'(1);
      if (dispatch) in_rd  <= in_rd + AW'(2);
      if (capture)  out_wr <= out_wr + AW'(2);
      if (pop_out)  out_rd <= out_rd + AW'(1);
      data_in_cnt  <= data_in_cnt + 4'(push_in) - (dispatch ? 4'd2 : 4'd0);
      data_out_cnt <= data_out_cnt + (capture ? 4'd2 : 4'd0) - 4'(pop_out);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst || soft_rst) begin
      core_block   <= '0;
      core_decrypt <= 1'b0;
    end else if (dispatch) begin
      core_block   <= {in_mem[in_rd][31:0], in_mem[in_rd + AW'(1)][31:0]};
      core_decrypt <= in_mem[in_rd][32];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst || soft_rst) begin
      key1 <= '0; key2 <= '0; key1_half <= 1'b0; key2_half <= 1'b0;
    end else begin
      if (mode == MODE_KEY1) begin
        if (key1_half) key1[31:0]  <= PWDATA;
        else           key1[63:32] <= PWDATA;
        key1_half <= !key1_half;
      end
      if (mode == MODE_KEY2) begin
        if (key2_half) key2[31:0]  <= PWDATA;
        else           key2[63:32] <= PWDATA;
        key2_half <= !key2_half;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) core_flush <= 1'b0;
    else        core_flush <= soft_rst;
  end
endmodule

// File: tb/tb_des_buffer_ctrl.sv
// tb/tb_des_buffer_ctrl.sv - directed scenarios plus a randomized run against a queue-based reference model.
module tb_des_buffer_ctrl;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  mode;
  logic [31:0] PWDATA;
  logic        core_ready, core_done;
  logic [63:0] core_result;
  logic [3:0]  data_in_cnt, data_out_cnt;
  logic [31:0] data_out;
  logic        core_start, core_decrypt, core_flush;
  logic [63:0] core_block, key1, key2;

  int errors = 0;
  int checks = 0;

  des_buffer_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .PWDATA(PWDATA),
    .core_ready(core_ready), .core_done(core_done), .core_result(core_result),
    .data_in_cnt(data_in_cnt), .data_out_cnt(data_out_cnt), .data_out(data_out),
    .core_start(core_start), .core_block(core_block), .core_decrypt(core_decrypt),
    .core_flush(core_flush), .key1(key1), .key2(key2)
  );

  always #5 clk = ~clk;

  // Reference model: FIFOs as queues, dispatch phase 0 waiting / 1 start / 2 awaiting result.
  logic [32:0] in_q[$];
  logic [31:0] out_q[$];
  int          ph;
  logic [63:0] m_blk, m_k1, m_k2;
  logic        m_dec, m_h1, m_h2, m_flush;

  task automatic model_clear();
    in_q.delete(); out_q.delete(); ph = 0;
    m_blk = '0; m_dec = 1'b0; m_k1 = '0; m_k2 = '0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] m, input logic [31:0] wd, input logic rdy,
                            input logic done, input logic [63:0] res);
    bit go, cap, full, popok;
    logic [32:0] a, b;
    logic [31:0] dummy;
    if (m == 3'd5) begin
      model_clear();
      m_flush = 1'b1;
      return;
    end
    m_flush = 1'b0;
    go    = (ph == 0) && (in_q.size() >= 2) && rdy && (out_q.size() <= 6);
    cap   = (ph == 2) && done;
    full  = (in_q.size() >= 8);
    popok = (m == 3'd6) && (out_q.size() > 0);
    if (go) begin
      a = in_q.pop_front();
      b = in_q.pop_front();
      m_blk = {a[31:0], b[31:0]};
      m_dec = a[32];
    end
    if ((m == 3'd1 || m == 3'd2) && !full) in_q.push_back({(m == 3'd2), wd});
    if (popok) dummy = out_q.pop_front();
    if (cap) begin
      out_q.push_back(res[63:32]);
      out_q.push_back(res[31:0]);
    end
    if (m == 3'd3) begin
      if (m_h1) m_k1[31:0] = wd; else m_k1[63:32] = wd;
      m_h1 = !m_h1;
    end
    if (m == 3'd4) begin
      if (m_h2) m_k2[31:0] = wd; else m_k2[63:32] = wd;
      m_h2 = !m_h2;
    end
    if (ph == 0)      ph = go ? 1 : 0;
    else if (ph == 1) ph = 2;
    else              ph = done ? 0 : 2;
  endtask

  task automatic cyc(input logic [2:0] m, input logic [31:0] wd);
    mode = m; PWDATA = wd;
    @(posedge clk); #1;
    mode = 3'd0; core_done = 1'b0;
  endtask

  task automatic hw_reset();
    mode = 3'd0; PWDATA = '0; core_ready = 1'b0; core_done = 1'b0; core_result = '0;
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (core_start) begin
        seen = 1'b1;
        break;
      end
      cyc(3'd0, 32'd0);
    end
  endtask

  task automatic run_block(input logic [31:0] hi, input logic [31:0] lo);
    bit seen;
    cyc(3'd1, hi); cyc(3'd1, lo);
    wait_start(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL run_block_start got=%0b exp=1", seen); end
    cyc(3'd0, 32'd0);
    core_done = 1'b1; core_result = {hi, lo};
    cyc(3'd0, 32'd0);
  endtask

  task automatic test_reset();
    bit seen;
    hw_reset();
    checks++;
    if ({data_in_cnt, data_out_cnt, data_out, core_start, core_block, core_decrypt, core_flush, key1, key2} !== '0) begin
      errors++; $display("FAIL reset_outputs got in=%0d out=%0d dout=%h start=%0b key1=%h", data_in_cnt, data_out_cnt, data_out, core_start, key1);
    end
    core_ready = 1'b1;
    cyc(3'd3, 32'h11112222);
    cyc(3'd1, 32'hA0A0A0A0); cyc(3'd1, 32'hB0B0B0B0);
    wait_start(seen);
    cyc(3'd0, 32'd0);
    cyc(3'd1, 32'hC0C0C0C0);
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({data_in_cnt, data_out_cnt, data_out, core_start, core_block, core_decrypt, core_flush, key1, key2} !== '0) begin
      errors++; $display("FAIL reset_mid_busy got in=%0d blk=%h dec=%0b key1=%h", data_in_cnt, core_block, core_decrypt, key1);
    end
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b1; core_result = 64'h1234_5678_9ABC_DEF0;
    cyc(3'd0, 32'd0);
    checks++; if (data_out_cnt !== 4'd0) begin errors++; $display("FAIL reset_late_done got=%0d exp=0", data_out_cnt); end
    cyc(3'd1, 32'h1); cyc(3'd1, 32'h2); cyc(3'd0, 32'd0);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL reset_fsm_idle got=%0b exp=1", core_start); end
  endtask

  task automatic test_encrypt();
    hw_reset();
    core_ready = 1'b1;
    cyc(3'd1, 32'h01234567);
    cyc(3'd1, 32'h89ABCDEF);
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL enc_early_start got=%0b exp=0", core_start); end
    cyc(3'd0, 32'd0);
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL enc_start got=%0b exp=1", core_start); end
    checks++; if (core_block !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL enc_block got=%h exp=0123456789abcdef", core_block); end
    checks++; if (core_decrypt !== 1'b0) begin errors++; $display("FAIL enc_decrypt got=%0b exp=0", core_decrypt); end
    cyc(3'd0, 32'd0);
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL enc_start_pulse got=%0b exp=0", core_start); end
    core_done = 1'b1; core_result = 64'hFEDCBA9876543210;
    cyc(3'd0, 32'd0);
    checks++; if (data_out_cnt !== 4'd2) begin errors++; $display("FAIL enc_out_cnt got=%0d exp=2", data_out_cnt); end
    checks++; if (data_out !== 32'hFEDCBA98) begin errors++; $display("FAIL enc_out_hi got=%h exp=fedcba98", data_out); end
    cyc(3'd6, 32'd0);
    checks++; if (data_out !== 32'h76543210) begin errors++; $display("FAIL enc_out_lo got=%h exp=76543210", data_out); end
    cyc(3'd6, 32'd0);
    checks++; if (data_out_cnt !== 4'd0 || data_out !== 32'd0) begin errors++; $display("FAIL enc_drained cnt=%0d dout=%h exp 0/0", data_out_cnt, data_out); end
    cyc(3'd6, 32'd0);
    checks++; if (data_out_cnt !== 4'd0) begin errors++; $display("FAIL enc_empty_pop got=%0d exp=0", data_out_cnt); end
  endtask

  task automatic test_full_fifo();
    bit seen;
    hw_reset();
    for (int i = 0; i < 9; i++) cyc(3'd2, 32'h100 + i);
    checks++; if (data_in_cnt !== 4'd8) begin errors++; $display("FAIL full_cnt got=%0d exp=8", data_in_cnt); end
    core_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_start(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_start%0d got=%0b exp=1", b, seen); end
      checks++;
      if (core_block !== {32'h100 + 32'(2*b), 32'h101 + 32'(2*b)} || core_decrypt !== 1'b1) begin
        errors++; $display("FAIL full_block%0d got=%h dec=%0b", b, core_block, core_decrypt);
      end
      cyc(3'd0, 32'd0);
      core_done = 1'b1; core_result = core_block;
      cyc(3'd0, 32'd0);
    end
    checks++; if (data_in_cnt !== 4'd0 || data_out_cnt !== 4'd8) begin errors++; $display("FAIL full_drain in=%0d out=%0d exp 0/8", data_in_cnt, data_out_cnt); end
  endtask

  task automatic test_keys();
    hw_reset();
    cyc(3'd3, 32'hAAAA0001); cyc(3'd3, 32'hAAAA0002);
    cyc(3'd4, 32'hBBBB0001); cyc(3'd4, 32'hBBBB0002);
    checks++; if (key1 !== 64'hAAAA0001AAAA0002) begin errors++; $display("FAIL key1 got=%h exp=aaaa0001aaaa0002", key1); end
    checks++; if (key2 !== 64'hBBBB0001BBBB0002) begin errors++; $display("FAIL key2 got=%h exp=bbbb0001bbbb0002", key2); end
    cyc(3'd3, 32'hCCCC0003);
    cyc(3'd5, 32'd0);
    checks++; if (key1 !== 64'd0 || key2 !== 64'd0) begin errors++; $display("FAIL keys_soft_rst key1=%h key2=%h exp 0", key1, key2); end
    checks++; if (core_flush !== 1'b1) begin errors++; $display("FAIL flush_pulse got=%0b exp=1", core_flush); end
    cyc(3'd3, 32'h12345678);
    checks++; if (core_flush !== 1'b0) begin errors++; $display("FAIL flush_once got=%0b exp=0", core_flush); end
    checks++; if (key1 !== 64'h1234567800000000) begin errors++; $display("FAIL key_half_rst got=%h exp=1234567800000000", key1); end
  endtask

  task automatic test_simultaneous();
    bit seen;
    hw_reset();
    core_ready = 1'b1;
    run_block(32'hA0, 32'hA1);
    run_block(32'hB0, 32'hB1);
    cyc(3'd6, 32'd0);
    checks++; if (data_out_cnt !== 4'd3) begin errors++; $display("FAIL sim_pre_cnt got=%0d exp=3", data_out_cnt); end
    cyc(3'd1, 32'hC0); cyc(3'd1, 32'hC1);
    wait_start(seen);
    cyc(3'd0, 32'd0);
    core_done = 1'b1; core_result = {32'hC0, 32'hC1};
    cyc(3'd6, 32'd0);
    checks++; if (data_out_cnt !== 4'd4) begin errors++; $display("FAIL sim_done_pop got=%0d exp=4", data_out_cnt); end
    checks++; if (data_out !== 32'hB0) begin errors++; $display("FAIL sim_head got=%h exp=b0", data_out); end
    hw_reset();
    cyc(3'd1, 32'hD0); cyc(3'd2, 32'hD1);
    core_ready = 1'b1;
    cyc(3'd1, 32'hD2);
    checks++; if (data_in_cnt !== 4'd1) begin errors++; $display("FAIL sim_push_dispatch got=%0d exp=1", data_in_cnt); end
    checks++; if (core_start !== 1'b1 || core_block !== {32'hD0, 32'hD1}) begin errors++; $display("FAIL sim_push_block start=%0b blk=%h", core_start, core_block); end
  endtask

  task automatic test_backpressure_wrap();
    bit seen, any_start;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    hw_reset();
    core_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_block(32'hC0DE0000 + 32'(2*k), 32'hC0DE0001 + 32'(2*k));
      exp_q.push_back(32'hC0DE0000 + 32'(2*k)); exp_q.push_back(32'hC0DE0001 + 32'(2*k));
    end
    e = exp_q.pop_front();
    checks++; if (data_out !== e) begin errors++; $display("FAIL bp_head got=%h exp=%h", data_out, e); end
    cyc(3'd6, 32'd0);
    run_block(32'hC0DE0006, 32'hC0DE0007);
    exp_q.push_back(32'hC0DE0006); exp_q.push_back(32'hC0DE0007);
    cyc(3'd1, 32'hC0DE0008); cyc(3'd1, 32'hC0DE0009);
    exp_q.push_back(32'hC0DE0008); exp_q.push_back(32'hC0DE0009);
    any_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_start |= core_start;
      cyc(3'd0, 32'd0);
    end
    checks++; if (any_start !== 1'b0 || data_out_cnt !== 4'd7) begin errors++; $display("FAIL bp_hold start=%0b out=%0d exp 0/7", any_start, data_out_cnt); end
    e = exp_q.pop_front();
    checks++; if (data_out !== e) begin errors++; $display("FAIL bp_pop got=%h exp=%h", data_out, e); end
    cyc(3'd6, 32'd0);
    wait_start(seen);
    checks++; if (seen !== 1'b1 || core_block !== 64'hC0DE0008C0DE0009) begin errors++; $display("FAIL bp_release seen=%0b blk=%h", seen, core_block); end
    cyc(3'd0, 32'd0);
    core_done = 1'b1; core_result = core_block;
    cyc(3'd0, 32'd0);
    checks++; if (data_out_cnt !== 4'd8) begin errors++; $display("FAIL bp_full got=%0d exp=8", data_out_cnt); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++; if (data_out !== e) begin errors++; $display("FAIL wrap_order%0d got=%h exp=%h", i, data_out, e); end
      cyc(3'd6, 32'd0);
    end
    checks++; if (data_out_cnt !== 4'd0) begin errors++; $display("FAIL wrap_empty got=%0d exp=0", data_out_cnt); end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] m;
    logic [31:0] wd;
    hw_reset();
    model_clear();
    m_flush = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if (r < 30) m = 3'd1; else if (r < 45) m = 3'd2; else if (r < 50) m = 3'd3;
      else if (r < 55) m = 3'd4; else if (r < 57) m = 3'd5; else if (r < 80) m = 3'd6; else m = 3'd0;
      wd = $urandom;
      core_ready = ($urandom_range(0, 3) != 0);
      core_done = ($urandom_range(0, 2) == 0);
      core_result = {$urandom, $urandom};
      model_step(m, wd, core_ready, core_done, core_result);
      cyc(m, wd);
      checks++;
      if (data_in_cnt !== 4'(in_q.size()) || data_out_cnt !== 4'(out_q.size())) begin
        errors++; $display("FAIL rnd_counts c=%0d in=%0d/%0d out=%0d/%0d", c, data_in_cnt, in_q.size(), data_out_cnt, out_q.size());
      end
      checks++;
      if (data_out !== ((out_q.size() > 0) ? out_q[0] : 32'd0)) begin
        errors++; $display("FAIL rnd_data_out c=%0d got=%h", c, data_out);
      end
      checks++;
      if (core_start !== (ph == 1) || core_block !== m_blk || core_decrypt !== m_dec) begin
        errors++; $display("FAIL rnd_core c=%0d start=%0b blk=%h/%h dec=%0b/%0b", c, core_start, core_block, m_blk, core_decrypt, m_dec);
      end
      checks++;
      if (key1 !== m_k1 || key2 !== m_k2 || core_flush !== m_flush) begin
        errors++; $display("FAIL rnd_keys c=%0d key1=%h/%h key2=%h/%h flush=%0b", c, key1, m_k1, key2, m_k2, core_flush);
      end
    end
  endtask

  initial begin
    n_rst = 1'b1; mode = 3'd0; PWDATA = '0;
    core_ready = 1'b0; core_done = 1'b0; core_result = '0;
    test_reset();
    test_encrypt();
    test_full_fifo();
    test_keys();
    test_simultaneous();
    test_backpressure_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/des_buffer_ctrl.md
# des_buffer_ctrl

Datapath buffer stage directly downstream of the APB slave FSM in the 3DES accelerator. It decodes the 3-bit `mode` command stream into actions:
- buffering 32-bit plaintext/ciphertext words into an input FIFO;
- loading the two 64-bit keys;
- dispatching 64-bit blocks to the 3DES core;
- collecting core results into an output FIFO for APB readback.

It supplies `data_in_cnt`, `data_out_cnt` and `data_out` back to the APB slave.

## Interface
Parameters:
- DEPTH, 8: words per FIFO (input and output); counts are 4 bits, range 0..8.

Ports:
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- mode  in  3  command from APB slave: 0 none, 1 enc write, 2 dec write, 3 key1 write, 4 key2 write, 5 soft reset, 6 read pop
- PWDATA  in  32  APB write data, sampled when mode is 1–4
- core_ready  in  1  3DES core idle, can accept a block
- core_done  in  1  one-cycle pulse, core_result valid
- core_result  in  64  processed block
- data_in_cnt  out  4  input FIFO occupancy, registered
- data_out_cnt  out  4  output FIFO occupancy, registered
- data_out  out  32  output FIFO head word; 0 when empty
- core_start  out  1  one-cycle block start pulse
- core_block  out  64  block to core, registered
- core_decrypt  out  1  1 = decrypt current block
- core_flush  out  1  one-cycle pulse on soft reset
- key1, key2  out  64 each  key registers

## Operation
- **Input FIFO.** DEPTH entries × {32-bit word, 1-bit dec tag}.
  - mode 1 pushes PWDATA with tag 0; mode 2 pushes PWDATA with tag 1.
  - A push when data_in_cnt == 8 is dropped; count and contents are unchanged.
- **Keys.** Each key has its own half-select flag, reset to 0.
  - mode 3: half flag 0 writes key1[63:32]; half flag 1 writes key1[31:0]. The flag toggles after each write.
  - mode 4 does the same for key2.
- **mode 5 (soft reset).** Same effect as n_rst on all state: FIFOs emptied, pointers and counts 0, keys 0, half flags 0, FSM to IDLE. core_flush pulses the next cycle.
- **mode 6 (read pop).** Pops the output FIFO head. data_out already shows the head combinationally in the mode-6 cycle. A pop when empty is ignored.
- **Dispatch FSM.** States IDLE, START, BUSY.
  - IDLE → START when data_in_cnt ≥ 2 && core_ready && data_out_cnt ≤ 6. On this edge:
    - core_block ← {oldest word, next word};
    - core_decrypt ← tag of the oldest word;
    - pop 2 input words.
  - START: core_start = 1 for exactly this cycle; → BUSY.
  - BUSY: wait for core_done. On core_done, push core_result[63:32] then core_result[31:0] (2 words, same edge); → IDLE.
  - core_done is ignored in IDLE and START.
- **Count arithmetic.** Each count is the registered sum of the same-edge events:
  - data_in_cnt: +1 for a push, −2 for a dispatch.
  - data_out_cnt: +2 for core_done capture, −1 for a pop.
  - The output room check (≤ 6) guarantees no overflow, because at most one block is in flight.
- **Pointers.** 3-bit read/write pointers wrap modulo 8.
- **Precedence.** mode 5 overrides all same-cycle events, including core_done capture and dispatch.

## Timing
- Reset (n_rst low or mode 5) values:
  - data_in_cnt = 0, data_out_cnt = 0, data_out = 0;
  - core_start = 0, core_block = 0, core_decrypt = 0, core_flush = 0;
  - key1 = 0, key2 = 0;
  - FSM = IDLE.
- Writes and pops: counts update on the clock edge ending the mode cycle, so they are visible the next cycle.
- Dispatch latency: with 2 words buffered and core_ready, core_start rises 1 cycle after the IDLE→START edge. The minimum from the second word's mode cycle to core_start is 2 cycles.
- Results: core_done in cycle N makes data_out_cnt += 2 and data_out valid (high word) in cycle N+1.
- Throughput: back-to-back blocks need 1 idle cycle (IDLE re-evaluation) after each core_done.

## Test plan
- **Reset.** Assert n_rst mid-BUSY → all outputs 0 and FSM IDLE. A later core_done is ignored; data_out_cnt stays 0.
- **Encrypt path.** mode 1 with 0x01234567, then mode 1 with 0x89ABCDEF, core_ready = 1 → core_start pulse with core_block = 0x0123456789ABCDEF, core_decrypt = 0. Then core_done with 0xFEDCBA9876543210 → data_out_cnt = 2, data_out = 0xFEDCBA98; mode 6 → data_out = 0x76543210; second mode 6 → data_out_cnt = 0.
- **Full input FIFO.** core_ready = 0, 9 mode-2 writes → data_in_cnt = 8 and the 9th word is absent. Raising core_ready dispatches with core_decrypt = 1 and the first two words.
- **Key load.** mode 3 ×2 (0xAAAA0001, 0xAAAA0002), mode 4 ×2 (0xBBBB0001, 0xBBBB0002) → key1 = 0xAAAA0001AAAA0002, key2 = 0xBBBB0001BBBB0002. Then mode 5 → both 0 and core_flush pulses once.
- **Simultaneous events.**
  - core_done in the same cycle as a mode-6 pop with data_out_cnt = 3 → data_out_cnt = 4.
  - A push in the same cycle as the IDLE→START dispatch with data_in_cnt = 2 → data_in_cnt = 1.
- **Output back-pressure and wrap.** Leave data_out_cnt = 7 with input words pending → no core_start. One mode 6 (count 6) → dispatch proceeds. Continue long enough for pointers to wrap past 8 and check word order is preserved.
